// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: valid/ready handshake, flush and gated write enables.
// Define WB_PIPE_SKID_EN for the 2-entry skid build with a registered in_ready.
module wb_pipe_reg #(
  parameter int PC_W  = 32,
  parameter int XLEN  = 32,
  parameter int IDX_W = 5,
  parameter int NCH   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [NCH*IDX_W-1:0]  in_rd_idx,
  input  logic [NCH-1:0]        in_rd_en,
  input  logic [NCH*XLEN-1:0]   in_rd_wdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_W-1:0]       out_pc,
  output logic [NCH*IDX_W-1:0]  out_rd_idx,
  output logic [NCH-1:0]        out_rd_en,
  output logic [NCH*XLEN-1:0]   out_rd_wdata
);

  localparam int PW = PC_W + NCH*IDX_W + NCH + NCH*XLEN;

  logic          m_vld_q, m_vld_d;
  logic [PW-1:0] m_pay_q, m_pay_d;
  logic [PW-1:0] in_pay;
  logic [NCH-1:0] m_en;
  logic          acc, fire;

  assign in_pay = {in_pc, in_rd_idx, in_rd_en, in_rd_wdata};
  assign {out_pc, out_rd_idx, m_en, out_rd_wdata} = m_pay_q;
  assign out_valid = m_vld_q;
  assign out_rd_en = m_en & {NCH{m_vld_q}};
  assign acc  = in_valid && in_ready;
  assign fire = m_vld_q && out_ready;

`ifdef WB_PIPE_SKID_EN
  logic          s_vld_q, s_vld_d;
  logic [PW-1:0] s_pay_q, s_pay_d;

  assign in_ready = !s_vld_q;

  always_comb begin
    m_vld_d = m_vld_q;
    m_pay_d = m_pay_q;
    s_vld_d = s_vld_q;
    s_pay_d = s_pay_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q) begin
      if (acc) begin
        m_vld_d = 1'b1;
        m_pay_d = in_pay;
      end
    end else if (fire) begin
      // a full skid entry always goes next; in_ready is low then
      if (s_vld_q) begin
        m_pay_d = s_pay_q;
        s_vld_d = 1'b0;
      end else if (acc) begin
        m_pay_d = in_pay;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (acc) begin
      s_vld_d = 1'b1;
      s_pay_d = in_pay;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_vld_q <= 1'b0;
      s_pay_q <= '0;
    end else begin
      s_vld_q <= s_vld_d;
      s_pay_q <= s_pay_d;
    end
  end
`else
  assign in_ready = !m_vld_q || out_ready;

  always_comb begin
    m_vld_d = m_vld_q;
    m_pay_d = m_pay_q;
    if (flush) begin
      m_vld_d = 1'b0;
    end else if (acc) begin
      m_vld_d = 1'b1;
      m_pay_d = in_pay;
    end else if (fire) begin
      m_vld_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      m_pay_q <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      m_pay_q <= m_pay_d;
    end
  end

endmodule
